// File: rtl/led_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : led_shift_out
// Summary  : Serialises the parallel LED bus onto a 74HC595-style SCLK/SDATA/
//            LATCH link, sending only values that differ from the last one.
// Revision : 1.0 - initial release
// ============================================================================
module led_shift_out #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] LED,
    output logic             SCLK,
    output logic             SDATA,
    output logic             LATCH,
    output logic             BUSY,
    output logic [15:0]      XFER_COUNT
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] c_ph_last  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] c_ph_high  = PW'(CLK_DIV);
    localparam logic [PW-1:0] c_lat_last = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_bit_last = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic             pending_q, pending_d;
    logic [PW-1:0]    phase_q,   phase_d;
    logic [BW-1:0]    bit_q,     bit_d;
    logic             sclk_q,    sclk_d;
    logic             sdata_q,   sdata_d;
    logic             latch_q,   latch_d;
    logic             busy_q,    busy_d;
    logic [15:0]      cnt_q,     cnt_d;

    logic             w_start;
    logic [WIDTH-1:0] w_shifted;

    assign w_start   = pending_q | (LED != shadow_q);
    assign w_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b1;
            phase_q   <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        latch_d   = latch_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    shreg_d   = LED;
                    shadow_d  = LED;
                    pending_d = 1'b0;
                    phase_d   = '0;
                    bit_d     = '0;
                    sclk_d    = 1'b0;
                    sdata_d   = MSB_FIRST ? LED[WIDTH-1] : LED[0];
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (phase_q == c_ph_last) begin
                    // End of a bit window: SCLK falls and the next bit is
                    // presented on the same edge.
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    if (bit_q == c_bit_last) begin
                        latch_d = 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = w_shifted;
                        sdata_d = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    sclk_d  = (phase_d >= c_ph_high);
                end
            end

            ST_LATCH: begin
                if (phase_q == c_lat_last) begin
                    phase_d = '0;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    sdata_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SCLK       = sclk_q;
    assign SDATA      = sdata_q;
    assign LATCH      = latch_q;
    assign BUSY       = busy_q;
    assign XFER_COUNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_out.sv
`default_nettype none
// Scoreboard bench for led_shift_out: three builds (MSB-first default,
// LSB-first default, WIDTH=1/CLK_DIV=1) observed by one negedge monitor.
module tb_led_shift_out;

    typedef struct packed {
        logic [7:0]  word;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [7:0]  led_a;
    logic [7:0]  led_b;
    logic [0:0]  led_c;
    logic        sclk  [3];
    logic        sdata [3];
    logic        latch [3];
    logic        busy  [3];
    logic [15:0] cnt   [3];
    logic        rstv  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign rstv[0] = rst_a;
    assign rstv[1] = rst_b;
    assign rstv[2] = rst_b;

    led_shift_out #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
        .CLK(clk), .RST(rst_a), .LED(led_a), .SCLK(sclk[0]), .SDATA(sdata[0]),
        .LATCH(latch[0]), .BUSY(busy[0]), .XFER_COUNT(cnt[0])
    );

    led_shift_out #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_b (
        .CLK(clk), .RST(rst_b), .LED(led_b), .SCLK(sclk[1]), .SDATA(sdata[1]),
        .LATCH(latch[1]), .BUSY(busy[1]), .XFER_COUNT(cnt[1])
    );

    led_shift_out #(.WIDTH(1), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_c (
        .CLK(clk), .RST(rst_b), .LED(led_c), .SCLK(sclk[2]), .SDATA(sdata[2]),
        .LATCH(latch[2]), .BUSY(busy[2]), .XFER_COUNT(cnt[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input int i, input logic [7:0] w, input logic [15:0] c);
        case (i)
            0:       q0.push_back(exp_t'({w, c}));
            1:       q1.push_back(exp_t'({w, c}));
            default: q2.push_back(exp_t'({w, c}));
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        e  = '0;
        ok = 1'b0;
        case (i)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int half_exp(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int bits_exp(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int len_exp(input int i);
        return (i == 2) ? 3 : 68;
    endfunction

    // ---------------- monitor ----------------
    int         blen  [3];
    int         nbits [3];
    int         run   [3];
    int         nlat  [3];
    logic [7:0] word  [3];
    bit         terr  [3];
    logic       psclk [3];
    logic       pbusy [3];
    logic       psdata[3];
    exp_t       mon_e;
    bit         mon_ok;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rstv[i]) begin
                blen[i] = 0; nbits[i] = 0; run[i] = 0; nlat[i] = 0;
                word[i] = '0; terr[i] = 1'b0;
                psclk[i] = 1'b0; pbusy[i] = 1'b0; psdata[i] = 1'b0;
            end else begin
                if (busy[i] && !pbusy[i]) begin
                    blen[i] = 0; nbits[i] = 0; run[i] = 0; nlat[i] = 0;
                    word[i] = '0; terr[i] = 1'b0;
                end
                if (busy[i]) begin
                    blen[i]++;
                    if (sclk[i] == psclk[i]) run[i]++;
                    else begin
                        if (run[i] != half_exp(i)) terr[i] = 1'b1;
                        run[i] = 1;
                    end
                    if (sclk[i] && !psclk[i]) begin
                        if (i == 0) word[i] = {word[i][6:0], sdata[i]};
                        else        word[i] = word[i] | (8'(sdata[i]) << nbits[i]);
                        nbits[i]++;
                    end
                    if (pbusy[i] && (sdata[i] != psdata[i]) && !(psclk[i] && !sclk[i]))
                        terr[i] = 1'b1;
                    if (latch[i]) begin
                        nlat[i]++;
                        if (sclk[i]) terr[i] = 1'b1;
                    end
                end
                if (!busy[i] && pbusy[i]) begin
                    chk($sformatf("u%0d busy length", i), blen[i], len_exp(i));
                    chk($sformatf("u%0d sclk pulses", i), nbits[i], bits_exp(i));
                    chk($sformatf("u%0d latch length", i), nlat[i], half_exp(i));
                    chk($sformatf("u%0d sclk/sdata timing", i), terr[i], 0);
                    chk($sformatf("u%0d sdata after xfer", i), sdata[i], 0);
                    pop_exp(i, mon_e, mon_ok);
                    chk($sformatf("u%0d transfer expected", i), mon_ok, 1);
                    if (mon_ok) begin
                        chk($sformatf("u%0d shifted word", i), word[i], mon_e.word);
                        chk($sformatf("u%0d xfer count", i), cnt[i], mon_e.cnt);
                    end
                end
                pbusy[i]  = busy[i];
                psclk[i]  = sclk[i];
                psdata[i] = sdata[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_all(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0 ||
                    busy[0] || busy[1] || busy[2]) && n < budget);
        chk("drain within budget", n < budget, 1);
    endtask

    task automatic wait_busy_a(input int budget);
        int n = 0;
        while (!busy[0] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy rise within budget", n < budget, 1);
    endtask

    initial begin
        int act;
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        led_a = 8'h00; led_b = 8'h00; led_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs u0", {busy[0], sclk[0], sdata[0], latch[0], cnt[0]}, 0);
        chk("reset outputs u1", {busy[1], sclk[1], sdata[1], latch[1], cnt[1]}, 0);
        chk("reset outputs u2", {busy[2], sclk[2], sdata[2], latch[2], cnt[2]}, 0);

        // forced initial transfer of the current value
        push_exp(0, 8'h00, 16'd1);
        push_exp(1, 8'h00, 16'd1);
        push_exp(2, 8'h00, 16'd1);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("start latency u0", busy[0], 1);
        chk("start latency u2", busy[2], 1);
        wait_all(2000);

        led_a = 8'hA5; push_exp(0, 8'hA5, 16'd2);
        led_b = 8'h01; push_exp(1, 8'h01, 16'd2);
        led_c = 1'b1;  push_exp(2, 8'h01, 16'd2);
        wait_all(2000);
        led_b = 8'hA5; push_exp(1, 8'hA5, 16'd3);
        wait_all(2000);

        // stable LED: link must stay quiet
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sclk[0] || latch[0] || busy[0]) act++;
        end
        chk("quiet activity", act, 0);
        chk("quiet count", cnt[0], 16'd2);

        // values arriving mid-transfer coalesce to the newest one
        led_a = 8'h01; push_exp(0, 8'h01, 16'd3);
        wait_busy_a(100);
        repeat (10) @(negedge clk);
        led_a = 8'h02;
        repeat (20) @(negedge clk);
        led_a = 8'h03; push_exp(0, 8'h03, 16'd4);
        wait_all(2000);
        chk("coalesce count", cnt[0], 16'd4);

        // A->B->A within a transfer produces no extra transfer
        led_a = 8'h10; push_exp(0, 8'h10, 16'd5);
        wait_busy_a(100);
        repeat (10) @(negedge clk);
        led_a = 8'h11;
        repeat (10) @(negedge clk);
        led_a = 8'h10;
        wait_all(2000);
        repeat (200) @(negedge clk);
        chk("A-B-A count", cnt[0], 16'd5);

        // asynchronous reset during the high phase of bit 3
        led_a = 8'h3C;
        n = 0;
        while (!(busy[0] && nbits[0] == 4 && sclk[0]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach bit3 high phase", n < 2000, 1);
        chk("pre-reset busy/sclk/sdata", {busy[0], sclk[0], sdata[0]}, 3'b111);
        #2 rst_a = 1'b1;
        #1 chk("async reset outputs", {busy[0], sclk[0], sdata[0], latch[0], cnt[0]}, 0);
        repeat (2) @(negedge clk);
        push_exp(0, 8'h3C, 16'd1);
        rst_a = 1'b0;
        wait_all(2000);
        chk("post-reset count", cnt[0], 16'd1);

        // counter wrap on the WIDTH=1 / CLK_DIV=1 build
        repeat (2) @(negedge clk);
        force u_c.cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_c.cnt_q;
        @(negedge clk);
        chk("preload count", cnt[2], 16'hFFFF);
        led_c = 1'b0; push_exp(2, 8'h00, 16'h0000);
        wait_all(200);
        led_c = 1'b1; push_exp(2, 8'h01, 16'h0001);
        wait_all(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/led_shift_out.md
Name: led_shift_out

Overview:
- Downstream stage of the LED counter block. It takes the parallel LED bus and serialises it onto a 74HC595-style shift-register interface (SCLK/SDATA/LATCH) that drives the physical LEDs.
- A transfer starts only when the LED value differs from the value last shifted out. A forced transfer after reset initialises the external register.
- Transfers are atomic. Intermediate LED values that appear during a transfer are dropped; only the newest value is sent next.

Parameters:
- WIDTH, 8, LED bus width and number of bits per transfer (>=1).
- CLK_DIV, 4, CLK cycles per SCLK half-period and per LATCH pulse (>=1).
- MSB_FIRST, 1, 1 = shift LED[WIDTH-1] first; 0 = LED[0] first.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- LED  input  WIDTH  parallel LED value from the upstream counter block; synchronous to CLK.
- SCLK  output  1  serial shift clock; external register samples on the SCLK rising edge.
- SDATA  output  1  serial data.
- LATCH  output  1  storage-register latch pulse, active high.
- BUSY  output  1  high while a transfer is in progress.
- XFER_COUNT  output  16  number of completed transfers.

Behaviour:
- Reset (async, takes effect immediately, including mid-transfer):
  - All registered outputs go to 0: SCLK=0, SDATA=0, LATCH=0, BUSY=0, XFER_COUNT=0.
  - shadow register=0, state=IDLE, pending=1.
- State machine states: IDLE, SHIFT, LATCH.
- IDLE:
  - Each cycle evaluate start = pending | (LED != shadow).
  - If start: capture LED into the shift register and into shadow, clear pending, go to SHIFT.
  - In the next cycle BUSY=1, SDATA = first bit, SCLK=0.
- SHIFT, per bit:
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SDATA is stable for the whole 2*CLK_DIV window.
  - SDATA changes only on the cycle SCLK returns low.
  - After the high phase of bit WIDTH-1: SCLK=0, go to LATCH.
- LATCH:
  - LATCH=1 for exactly CLK_DIV cycles; SCLK=0; SDATA holds the last bit.
  - On the final LATCH cycle, XFER_COUNT increments, wrapping 0xFFFF -> 0x0000.
  - Then LATCH=0, BUSY=0, SDATA=0, go to IDLE.
- Timing:
  - BUSY stays high for exactly 2*CLK_DIV*WIDTH + CLK_DIV cycles (68 at the defaults).
  - Start latency: first BUSY cycle is 1 cycle after the IDLE cycle that saw start.
  - At least 1 IDLE cycle separates consecutive transfers.
- LED changes during SHIFT/LATCH are ignored and do not corrupt the transfer. After returning to IDLE, LED is compared to shadow again; if it differs, the current LED value is sent. An A->B->A change within one transfer causes no new transfer.
- Every output is a register output with no combinational path from LED.
- Bit order: MSB_FIRST selects the first bit and shift direction.
- WIDTH=1 and CLK_DIV=1 must work.

Test Plan:
- Reset release, LED=0x00, defaults:
  - BUSY rises 1 cycle after the first IDLE cycle and lasts 68 cycles.
  - 8 SCLK pulses, each 4 low / 4 high; SDATA=0 throughout.
  - LATCH high for 4 cycles; XFER_COUNT=1.
- LED changes to 0xA5 in IDLE, MSB_FIRST=1:
  - Sampled bits on SCLK rising edges are 1,0,1,0,0,1,0,1.
  - XFER_COUNT=2.
  - With MSB_FIRST=0, 0xA5 samples as 1,0,1,0,0,1,0,1 (palindrome), so also check 0x01: first sampled bit is 1 and the remaining seven are 0.
- LED held constant after a transfer for 1000 cycles -> no SCLK/LATCH activity; BUSY=0; XFER_COUNT unchanged.
- During a transfer of 0x01, LED steps 0x02 -> 0x03 ->
  - The current transfer completes with 0x01.
  - Exactly one further transfer of 0x03 follows; 0x02 is never sent.
  - XFER_COUNT advances by 2 in total.
- Assert RST mid-SHIFT (bit 3 high phase) -> outputs go to 0 in the same cycle without a clock edge. After release, a fresh full transfer of the current LED value occurs (pending=1).
- Force XFER_COUNT to 0xFFFF via 65535 transfers (or a bench preload) -> the next transfer wraps it to 0x0000; WIDTH=1, CLK_DIV=1 build gives BUSY=3 cycles per transfer.
